// File: rtl/ctrl_pkg.sv
// Shared definitions for the memory stage and the ControlUnit that feeds it.
// Holds the stage FSM encoding, the decode constants and an alignment helper.
package ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } mem_state_e;

  // Opcode encodings decoded by ControlUnit
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // aluOp encodings driven by ControlUnit
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/access_timer.sv
// Counts cycles spent waiting for the data memory.
// expired is asserted while the count equals TIMEOUT.
module access_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Saturates at TIMEOUT so a missed clear can never wrap into a false restart
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CW'(TIMEOUT))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == CW'(TIMEOUT));

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-access stage: runs a req/ack data-memory handshake for loads/stores
// and emits one writeback beat per accepted instruction.
module mem_stage_ctrl
  import ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reg_write,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [4:0]        rd,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              bus_err
);

  mem_state_e        state_q, state_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
  logic              reg_write_cap_q, reg_write_cap_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              bus_err_q, bus_err_d;
  logic              timer_expired;
  logic              timer_run;

  always_comb begin
    state_d         = state_q;
    dmem_req_d      = dmem_req_q;
    dmem_we_d       = dmem_we_q;
    dmem_addr_d     = dmem_addr_q;
    dmem_wdata_d    = dmem_wdata_q;
    reg_write_cap_d = reg_write_cap_q;
    wb_reg_write_d  = wb_reg_write_q;
    wb_rd_d         = wb_rd_q;
    wb_data_d       = wb_data_q;
    bus_err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          wb_rd_d         = rd;
          reg_write_cap_d = reg_write;
          if (!mem_read && !mem_write) begin
            wb_data_d      = alu_result;
            wb_reg_write_d = reg_write;
            state_d        = RESP;
          end else if ((mem_read ^ mem_write) && word_aligned(alu_result[1:0])) begin
            dmem_req_d   = 1'b1;
            dmem_we_d    = mem_write;
            dmem_addr_d  = alu_result[ADDR_W-1:0];
            dmem_wdata_d = store_data;
            state_d      = ACCESS;
          end else begin
            // Conflicting flags or misaligned address: never touch memory
            bus_err_d      = 1'b1;
            wb_reg_write_d = 1'b0;
            state_d        = RESP;
          end
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          dmem_req_d = 1'b0;
          state_d    = RESP;
          if (dmem_we_q) begin
            wb_reg_write_d = 1'b0;
          end else begin
            wb_data_d      = dmem_rdata;
            wb_reg_write_d = reg_write_cap_q;
          end
        end else if (timer_expired) begin
          dmem_req_d     = 1'b0;
          bus_err_d      = 1'b1;
          wb_reg_write_d = 1'b0;
          state_d        = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        dmem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      dmem_req_q      <= 1'b0;
      dmem_we_q       <= 1'b0;
      dmem_addr_q     <= '0;
      dmem_wdata_q    <= '0;
      reg_write_cap_q <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_rd_q         <= '0;
      wb_data_q       <= '0;
      bus_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      dmem_req_q      <= dmem_req_d;
      dmem_we_q       <= dmem_we_d;
      dmem_addr_q     <= dmem_addr_d;
      dmem_wdata_q    <= dmem_wdata_d;
      reg_write_cap_q <= reg_write_cap_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_rd_q         <= wb_rd_d;
      wb_data_q       <= wb_data_d;
      bus_err_q       <= bus_err_d;
    end
  end

  // Counting on the next state makes the count equal the ACCESS cycle number
  assign timer_run = (state_d == ACCESS);

  access_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!timer_run),
    .enable (timer_run),
    .expired(timer_expired)
  );

  assign in_ready     = (state_q == IDLE);
  assign stall        = in_valid & ~in_ready;
  assign wb_valid     = (state_q == RESP);
  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              rw;
        logic [4:0]        rd;
        logic              err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              reg_write = 1'b0;
    logic              mem_write = 1'b0;
    logic              mem_read = 1'b0;
    logic [DATA_W-1:0] alu_result = '0;
    logic [DATA_W-1:0] store_data = '0;
    logic [4:0]        rd = '0;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack = 1'b0;
    logic [DATA_W-1:0] dmem_rdata = '0;
    logic              wb_valid;
    logic              wb_reg_write;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              stall;
    logic              bus_err;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [DATA_W-1:0] last_wb_data = '0;

    function automatic void chk(input string tag, input logic ok,
                                input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (ok !== 1'b1) begin
            fails++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endfunction

    mem_stage_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .alu_result  (alu_result),
        .store_data  (store_data),
        .rd          (rd),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .wb_valid    (wb_valid),
        .wb_reg_write(wb_reg_write),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .stall       (stall),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (wb_valid) begin
                chk("wb_expected", sb.size() != 0, sb.size(), 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("wb_data", wb_data === mon_e.data, wb_data, mon_e.data);
                    chk("wb_reg_write", wb_reg_write === mon_e.rw, wb_reg_write, mon_e.rw);
                    chk("wb_rd", wb_rd === mon_e.rd, wb_rd, mon_e.rd);
                    chk("bus_err", bus_err === mon_e.err, bus_err, mon_e.err);
                    $display("[TB] wb rd=%0d data=%08h reg_write=%0b bus_err=%0b",
                             wb_rd, wb_data, wb_reg_write, bus_err);
                end
            end else begin
                chk("bus_err_quiet", bus_err === 1'b0, bus_err, 0);
            end
        end
    end

    task automatic run_op(input logic rw, input logic mw, input logic mr,
                          input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] sd,
                          input logic [4:0] r, input int ack_at,
                          input logic [DATA_W-1:0] rdata);
        logic legal;
        exp_t e;
        legal = (mw ^ mr) && (alu[1:0] == 2'b00);
        if (!mw && !mr) begin
            e = '{data: alu, rw: rw, rd: r, err: 1'b0};
        end else if (!legal) begin
            e = '{data: last_wb_data, rw: 1'b0, rd: r, err: 1'b1};
        end else if (ack_at >= 1 && ack_at <= TIMEOUT) begin
            e = mr ? '{data: rdata, rw: rw, rd: r, err: 1'b0}
                   : '{data: last_wb_data, rw: 1'b0, rd: r, err: 1'b0};
        end else begin
            e = '{data: last_wb_data, rw: 1'b0, rd: r, err: 1'b1};
        end
        last_wb_data = e.data;
        sb.push_back(e);

        @(negedge clk);
        chk("in_ready_idle", in_ready === 1'b1, in_ready, 1);
        in_valid   = 1'b1;
        reg_write  = rw;
        mem_write  = mw;
        mem_read   = mr;
        alu_result = alu;
        store_data = sd;
        rd         = r;
        dmem_rdata = 32'hBAD0_BAD0;
        #1;
        chk("stall_idle", stall === 1'b0, stall, 0);
        @(negedge clk);
        if (legal) begin
            for (int c = 1; c <= TIMEOUT; c++) begin
                chk("dmem_req_held", dmem_req === 1'b1, dmem_req, 1);
                chk("dmem_we", dmem_we === mw, dmem_we, mw);
                chk("dmem_addr", dmem_addr === alu, dmem_addr, alu);
                chk("stall_access", stall === 1'b1, stall, 1);
                if (mw) chk("dmem_wdata", dmem_wdata === sd, dmem_wdata, sd);
                if (c == ack_at) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end
                if (c == ack_at || c == TIMEOUT) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                    dmem_ack = 1'b0;
                    break;
                end
                @(negedge clk);
            end
        end else begin
            in_valid = 1'b0;
        end
        chk("wb_valid_resp", wb_valid === 1'b1, wb_valid, 1);
        chk("dmem_req_resp", dmem_req === 1'b0, dmem_req, 0);
        chk("in_ready_resp", in_ready === 1'b0, in_ready, 0);
        @(negedge clk);
        chk("in_ready_after", in_ready === 1'b1, in_ready, 1);
        chk("wb_valid_after", wb_valid === 1'b0, wb_valid, 0);
        chk("wb_data_hold", wb_data === e.data, wb_data, e.data);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready === 1'b1, in_ready, 1);
        chk("rst_dmem_req", dmem_req === 1'b0, dmem_req, 0);
        chk("rst_wb_valid", wb_valid === 1'b0, wb_valid, 0);
        chk("rst_bus_err", bus_err === 1'b0, bus_err, 0);
        chk("rst_wb_data", wb_data === 32'h0, wb_data, 0);
        chk("rst_dmem_addr", dmem_addr === 32'h0, dmem_addr, 0);
        rst_n = 1'b1;

        run_op(1'b1, 1'b0, 1'b0, 32'h0000_002A, 32'h0, 5'd3, 0, 32'h0);
        run_op(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 5'd5, 3, 32'hDEAD_BEEF);
        run_op(1'b0, 1'b1, 1'b0, 32'h0000_0104, 32'h55, 5'd6, 2, 32'h0);
        run_op(1'b1, 1'b0, 1'b1, 32'h0000_0102, 32'h0, 5'd7, 1, 32'h1111_1111);
        run_op(1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h9, 5'd8, 1, 32'h2222_2222);
        run_op(1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0, 5'd9, 0, 32'h0);
        run_op(1'b1, 1'b0, 1'b1, 32'h0000_0304, 32'h0, 5'd10, TIMEOUT, 32'hCAFE_F00D);
        run_op(1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h0, 5'd31, 0, 32'h0);

        @(negedge clk);
        in_valid   = 1'b1;
        reg_write  = 1'b1;
        mem_write  = 1'b0;
        mem_read   = 1'b1;
        alu_result = 32'h0000_0400;
        rd         = 5'd12;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_req", dmem_req === 1'b1, dmem_req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_req", dmem_req === 1'b0, dmem_req, 0);
        chk("midrst_wb_valid", wb_valid === 1'b0, wb_valid, 0);
        chk("midrst_in_ready", in_ready === 1'b1, in_ready, 1);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h3333_3333;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("late_ack_wb_valid", wb_valid === 1'b0, wb_valid, 0);
        chk("late_ack_req", dmem_req === 1'b0, dmem_req, 0);
        chk("late_ack_in_ready", in_ready === 1'b1, in_ready, 1);
        chk("late_ack_wb_data", wb_data === 32'h0, wb_data, 0);
        last_wb_data = '0;

        run_op(1'b1, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 5'd1, 0, 32'h0);

        @(negedge clk);
        chk("scoreboard_empty", sb.size() == 0, sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
